// File: rtl/vector_ack_decoder_if.sv
// Bus between event sources/CPU and the pending-event latch and acknowledge decoder.
// The slave side is the decoder; the master side is whoever drives events, mask and acks.
interface vector_ack_decoder_if #(
    parameter int NUM_INPUTS = 16
);
    logic [NUM_INPUTS-1:0] event_in;
    logic                  mask_we;
    logic [NUM_INPUTS-1:0] mask_wdata;
    logic                  ack_strobe;
    logic [15:0]           ack_code;
    logic [NUM_INPUTS-1:0] pending_out;
    logic                  any_pending;
    logic [NUM_INPUTS-1:0] grant;
    logic                  ack_done;
    logic                  ack_err;

    modport slave (
        input  event_in, mask_we, mask_wdata, ack_strobe, ack_code,
        output pending_out, any_pending, grant, ack_done, ack_err
    );

    modport master (
        output event_in, mask_we, mask_wdata, ack_strobe, ack_code,
        input  pending_out, any_pending, grant, ack_done, ack_err
    );
endinterface

// File: rtl/vector_ack_decoder.sv
// Latches rising edges of event lines as pending, exports pending & mask, and clears
// the line named by an acknowledged vector code two edges after the ack strobe.
module vector_ack_decoder #(
    parameter int NUM_INPUTS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vector_ack_decoder_if.slave  bus
);
    localparam int                    TOP_INPUT = NUM_INPUTS - 1;
    localparam logic [31:0]           TOP_W     = 32'(TOP_INPUT);
    localparam logic [NUM_INPUTS-1:0] ONE_LSB   = NUM_INPUTS'(1);

    logic [NUM_INPUTS-1:0] pending_q, pending_d;
    logic [NUM_INPUTS-1:0] mask_q, mask_d;
    logic [NUM_INPUTS-1:0] prev_q;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] clr_onehot;
    logic [NUM_INPUTS-1:0] grant_q, grant_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ack_vld_q;
    logic                  ack_in_range_q;
    logic [15:0]           ack_code_q;

    always_comb begin
        rise       = bus.event_in & ~prev_q;
        clr_onehot = '0;
        grant_d    = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (ack_vld_q) begin
            if (ack_in_range_q) begin
                clr_onehot = ONE_LSB << ack_code_q;
                grant_d    = clr_onehot;
                done_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        // a new edge on the line being cleared must survive, so set is applied last
        pending_d = (pending_q & ~clr_onehot) | rise;
        mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    // prev resets to all ones so lines already high at reset release are not captured
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= '0;
            mask_q         <= '0;
            prev_q         <= '1;
            grant_q        <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            ack_vld_q      <= 1'b0;
            ack_in_range_q <= 1'b0;
            ack_code_q     <= '0;
        end else begin
            pending_q      <= pending_d;
            mask_q         <= mask_d;
            prev_q         <= bus.event_in;
            grant_q        <= grant_d;
            done_q         <= done_d;
            err_q          <= err_d;
            ack_vld_q      <= bus.ack_strobe;
            ack_in_range_q <= ({16'd0, bus.ack_code} <= TOP_W);
            ack_code_q     <= bus.ack_code;
        end
    end

    assign bus.pending_out = pending_q & mask_q;
    assign bus.any_pending = |(pending_q & mask_q);
    assign bus.grant       = grant_q;
    assign bus.ack_done    = done_q;
    assign bus.ack_err     = err_q;
endmodule

// File: tb/tb_vector_ack_decoder.sv
// Directed and random stimulus for vector_ack_decoder checked against a per-line
// behavioural model of pending events and in-flight acknowledges.
module tb_vector_ack_decoder;
    localparam int N  = 16;
    localparam int NB = 65536;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vector_ack_decoder_if #(.NUM_INPUTS(N))  bus  ();
    vector_ack_decoder_if #(.NUM_INPUTS(NB)) bbus ();

    vector_ack_decoder #(.NUM_INPUTS(N))  dut     (.clk(clk), .reset_n(reset_n), .bus(bus));
    vector_ack_decoder #(.NUM_INPUTS(NB)) dut_big (.clk(clk), .reset_n(reset_n), .bus(bbus));

    int vectors = 0;
    int miscompares = 0;

    bit m_pend [N];
    bit m_prev [N];
    bit m_mask [N];
    int m_inflight;
    int e_grant_line;
    bit e_done;
    bit e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b1;
            m_mask[i] = 1'b0;
        end
        m_inflight   = -1;
        e_grant_line = -1;
        e_done       = 1'b0;
        e_err        = 1'b0;
    endtask

    // one clock edge of the intended behaviour, using the inputs presented at that edge
    task automatic model_edge();
        e_grant_line = -1;
        e_done       = 1'b0;
        e_err        = 1'b0;
        if (m_inflight >= 0) begin
            if (m_inflight < N) begin
                e_grant_line       = m_inflight;
                e_done             = 1'b1;
                m_pend[m_inflight] = 1'b0;
            end else begin
                e_err = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.event_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev[i] = bus.event_in[i];
        end
        m_inflight = bus.ack_strobe ? int'(bus.ack_code) : -1;
        if (bus.mask_we)
            for (int i = 0; i < N; i++) m_mask[i] = bus.mask_wdata[i];
    endtask

    function automatic logic [31:0] exp_pending();
        int r = 0;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_mask[i]) r = r + (1 << i);
        return 32'(r);
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] ep;
        ep = exp_pending();
        check({tag, ".pending_out"}, 32'(bus.pending_out), ep);
        check({tag, ".any_pending"}, 32'(bus.any_pending), 32'(ep != 0));
        check({tag, ".grant"}, 32'(bus.grant), (e_grant_line >= 0) ? (32'd1 << e_grant_line) : 32'd0);
        check({tag, ".ack_done"}, 32'(bus.ack_done), 32'(e_done));
        check({tag, ".ack_err"}, 32'(bus.ack_err), 32'(e_err));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (reset_n) model_edge();
        else         model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic ack(input logic [15:0] code);
        bus.ack_strobe = 1'b1;
        bus.ack_code   = code;
    endtask

    task automatic idle_inputs();
        bus.mask_we    = 1'b0;
        bus.ack_strobe = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.event_in    = 16'h0001;
        bus.mask_we     = 1'b1;
        bus.mask_wdata  = 16'hFFFF;
        bus.ack_strobe  = 1'b0;
        bus.ack_code    = 16'h0000;
        bbus.event_in   = '0;
        bbus.mask_we    = 1'b0;
        bbus.mask_wdata = '0;
        bbus.ack_strobe = 1'b0;
        bbus.ack_code   = 16'h0000;

        // reset with line 0 held high through release
        cyc("rst0");
        cyc("rst1");
        @(negedge clk) reset_n = 1'b1;
        cyc("t1_mask");
        bus.mask_we = 1'b0;
        cyc("t1_held");
        bus.event_in = 16'h0021;
        cyc("t1_rise5");
        bus.event_in = 16'h0020;
        cyc("t1_fall0");
        bus.event_in = 16'h0021;
        cyc("t1_rise0");
        bus.event_in = 16'h0000;

        // ack line 5 with lines 0 and 5 pending
        ack(16'd5);
        cyc("t2_a");
        idle_inputs();
        cyc("t2_a1");
        cyc("t2_a2");

        // out-of-range code, then code 0
        ack(16'd16);
        cyc("t3_err_a");
        ack(16'd0);
        cyc("t3_err_a1");
        idle_inputs();
        cyc("t3_zero_a1");
        cyc("t3_idle");

        // clear and new rising edge of line 3 on the same edge
        ack(16'd3);
        cyc("t4_a");
        idle_inputs();
        bus.event_in = 16'h0008;
        cyc("t4_setclr");
        bus.event_in = 16'h0000;
        cyc("t4_idle");

        // masked lines still latch
        bus.mask_we = 1'b1; bus.mask_wdata = 16'h0000;
        cyc("t5_mask0");
        bus.mask_we = 1'b0; bus.event_in = 16'h0204;
        cyc("t5_events");
        bus.event_in = 16'h0000;
        cyc("t5_hidden");
        bus.mask_we = 1'b1; bus.mask_wdata = 16'h0200;
        cyc("t5_unmask");
        bus.mask_we = 1'b0;
        cyc("t5_hold");

        // drain everything with back-to-back acks, then acks 1,2,3 with 000E pending
        bus.mask_we = 1'b1; bus.mask_wdata = 16'hFFFF;
        for (int c = 0; c < N; c++) begin
            ack(16'(c));
            cyc("t6_drain");
            bus.mask_we = 1'b0;
        end
        idle_inputs();
        cyc("t6_drained");
        bus.event_in = 16'h000E;
        cyc("t6_rise");
        bus.event_in = 16'h0000;
        for (int c = 1; c <= 3; c++) begin
            ack(16'(c));
            cyc("t6_b2b");
        end
        idle_inputs();
        cyc("t6_last");
        cyc("t6_idle");

        // top line of the 65536-wide instance acknowledged by code FFFF
        bbus.mask_we = 1'b1; bbus.mask_wdata = '1;
        cyc("big_mask");
        bbus.mask_we = 1'b0;
        bbus.event_in[NB-1] = 1'b1;
        cyc("big_rise");
        check("big_pending_set", 32'(bbus.pending_out[NB-1]), 32'd1);
        bbus.ack_strobe = 1'b1; bbus.ack_code = 16'hFFFF;
        cyc("big_ack_a");
        bbus.ack_strobe = 1'b0;
        cyc("big_ack_a1");
        check("big_grant_top", 32'(bbus.grant[NB-1]), 32'd1);
        check("big_grant_count", 32'($countones(bbus.grant)), 32'd1);
        check("big_ack_done", 32'(bbus.ack_done), 32'd1);
        check("big_ack_err", 32'(bbus.ack_err), 32'd0);
        check("big_pending_clr", 32'(bbus.pending_out[NB-1]), 32'd0);

        // reset asserted while an ack is in flight
        bus.event_in = 16'h0004;
        cyc("mr_rise");
        ack(16'd2);
        cyc("mr_ack_a");
        idle_inputs();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("mr_in_reset");
        @(negedge clk) reset_n = 1'b1;
        cyc("mr_rel0");
        cyc("mr_rel1");

        // random traffic
        bus.mask_we = 1'b1; bus.mask_wdata = 16'(($urandom));
        cyc("rnd_mask");
        for (int k = 0; k < 400; k++) begin
            bus.event_in   = 16'($urandom);
            bus.mask_we    = ($urandom_range(0, 7) == 0);
            bus.mask_wdata = 16'($urandom);
            bus.ack_strobe = 1'($urandom_range(0, 1));
            bus.ack_code   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
            cyc("rnd");
        end
        idle_inputs();
        cyc("rnd_tail0");
        cyc("rnd_tail1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
